trap_sequencer: RTL
===================

# trap_sequencer

Sequences every control-flow change of the privileged unit: M-stage synchronous exceptions, machine interrupts and `mret`. It picks the highest-priority event at an M-stage instruction boundary and drives a one-cycle trap or `mret` commit pulse to the CSR file. It then holds a pipeline flush until fetch accepts the redirect to the trap vector or `mepc`. It sits between the M stage, `cs_registers` and the fetch redirect port.

## Interface
- No parameters.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `stallM_i` in 1: M stage stalled; no event is accepted while high.
- `instr_validM_i` in 1: M holds a real (non-bubble) instruction.
- `pcM_i` in 32: PC of the M instruction.
- `exc_valid_i` in 1: synchronous exception on the M instruction.
- `exc_cause_i` in 4: exception code.
- `exc_tval_i` in 32: exception mtval.
- `mret_i` in 1: M instruction is `mret`.
- `irq_pending_i` in 3: raw pending {MEI, MTI, MSI}, bit0 = MSI.
- `irq_enable_i` in 3: mie bits, same order.
- `mstatus_mie_i` in 1: global interrupt enable.
- `csr_mtvec_i` in 32: mtvec (base [31:2], mode [1:0]).
- `csr_mepc_i` in 32: mepc.
- `redirect_ready_i` in 1: fetch accepts the redirect.
- `trap_o` out 1: one-cycle trap commit to the CSR file.
- `mret_o` out 1: one-cycle mret commit.
- `trap_irq_o` out 1: mcause.irq.
- `trap_code_o` out 4: mcause code.
- `trap_mepc_o` out 32: PC to save.
- `trap_mtval_o` out 32: mtval to save.
- `flush_o` out 1: kill all F–M instructions.
- `redirect_valid_o` out 1: redirect request.
- `redirect_pc_o` out 32: redirect target.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- States: IDLE, TRAP, MRET, REDIRECT.
- IDLE accepts an event only if `instr_validM_i & ~stallM_i`. Priority:
  1. exception: latch irq=0, code=`exc_cause_i`, mepc=`pcM_i`, tval=`exc_tval_i`; go to TRAP.
  2. interrupt, when `mstatus_mie_i & |(irq_pending_i & irq_enable_i)`: latch irq=1, mepc=`pcM_i`, tval=0; go to TRAP. Code is chosen among enabled pending bits in the order MEI=11 > MSI=3 > MTI=7. The interrupted M instruction is not retired.
  3. `mret_i`: go to MRET.
- TRAP: `trap_o`=1 and `flush_o`=1. Latch target from `csr_mtvec_i`:
  - direct mode: {base,2'b00}.
  - vectored mode (see Configuration, interrupts only): {base,2'b00} + 4·code, computed mod 2^32.
  - Next state REDIRECT.
- MRET: `mret_o`=1 and `flush_o`=1. Latch target = {`csr_mepc_i`[31:2],2'b00}. Next state REDIRECT.
- REDIRECT: `redirect_valid_o`=1 and `flush_o`=1. Target is held stable until a cycle with `redirect_ready_i`=1, then IDLE.
- Any input events outside IDLE are ignored; those instructions are flushed.
- `trap_code_o`, `trap_irq_o`, `trap_mepc_o` and `trap_mtval_o` are registered and valid while `trap_o` is high. They hold their values otherwise.

## Timing
- Reset: state IDLE; every output 0.
- Reset asserted mid-sequence aborts the sequence immediately (asynchronous); no pulse is completed.
- Acceptance in cycle N: `trap_o`/`mret_o` in N+1, `redirect_valid_o` from N+2.
- Minimum event-to-IDLE latency is 3 cycles (ready already high).
- `redirect_ready_i` held low stretches REDIRECT indefinitely.
- Exception and `mret_i` in the same cycle: exception wins.
- Interrupt and `mret_i` in the same cycle: interrupt wins; mepc = PC of the `mret`.
- Stall in cycle N defers acceptance; pending state is re-evaluated every IDLE cycle.
- Pending interrupt with `instr_validM_i`=0 waits for the next valid instruction.

## Configuration
- `YARC_VECTORED_IRQ_EN` defined: mtvec mode 1 vectors interrupts to base+4·code; exceptions always go to base.
- Not defined: mtvec[1:0] ignored; every trap goes to {base,2'b00}.

## Test plan
- Exception code 2, pcM=0x100, tval=0xDEAD, mtvec=0x8000_0000 → `trap_o` at N+1 with code 2, irq=0, mepc 0x100, tval 0xDEAD; redirect 0x8000_0000 at N+2.
- MTI+MEI pending and enabled, MIE=1, mtvec=0x400 mode 1, macro on → code 11, irq=1, redirect 0x42C. Macro off → 0x400.
- Exception with `mret_i` and a pending irq in the same cycle → trap with the exception code; no `mret_o`.
- `mret_i`, mepc=0x204 → `mret_o` at N+1; redirect 0x204. `redirect_ready_i` low 5 cycles → valid and target held; IDLE one cycle after ready.
- Interrupt pending with `stallM_i`=1 for 4 cycles → no pulse until the first unstalled valid cycle.
- `rst_i` asserted in REDIRECT → outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: selects the highest-priority M-stage control-flow event
// (synchronous exception, machine interrupt or mret). It then issues a one-cycle
// commit pulse to the CSR file and holds a pipeline flush until fetch takes the
// redirect.
//
// Optional feature: define YARC_VECTORED_IRQ_EN so that mtvec mode 1 vectors
// interrupts to base + 4*code. When the macro is undefined, mtvec[1:0] is
// ignored and every trap goes to the base address.
//
// Handshake: redirect_valid_o is raised in REDIRECT and redirect_pc_o stays
// stable until a cycle in which redirect_ready_i is also high. That cycle
// completes the transfer and the FSM returns to IDLE on the following edge.
module trap_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stallM_i,
  input  logic        instr_validM_i,
  input  logic [31:0] pcM_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic [2:0]  irq_pending_i,
  input  logic [2:0]  irq_enable_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic        redirect_ready_i,
  output logic        trap_o,
  output logic        mret_o,
  output logic        trap_irq_o,
  output logic [3:0]  trap_code_o,
  output logic [31:0] trap_mepc_o,
  output logic [31:0] trap_mtval_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP     = 2'd1,
    ST_MRET     = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // state_q is the single place to probe the FSM position
  state_t      state_q;
  state_t      state_d;

  logic        irq_q;
  logic [3:0]  code_q;
  logic [31:0] mepc_q;
  logic [31:0] tval_q;
  logic [31:0] target_q;

  logic [2:0]  irq_active;
  logic        irq_take;
  logic        accept;
  logic [3:0]  irq_code;
  logic [31:0] trap_target;

  // Event qualification and interrupt code selection (MEI > MSI > MTI)
  always_comb begin
    irq_active = irq_pending_i & irq_enable_i;
    irq_take   = mstatus_mie_i & (|irq_active);
    accept     = (state_q == ST_IDLE) & instr_validM_i & ~stallM_i;
    irq_code   = 4'd7;
    if (irq_active[2]) begin
      irq_code = 4'd11;
    end else if (irq_active[0]) begin
      irq_code = 4'd3;
    end
  end

  // Trap vector; exceptions always use the base address
  always_comb begin
    trap_target = {csr_mtvec_i[31:2], 2'b00};
`ifdef YARC_VECTORED_IRQ_EN
    if (irq_q && (csr_mtvec_i[1:0] == 2'b01)) begin
      trap_target = {csr_mtvec_i[31:2], 2'b00} + {26'd0, code_q, 2'b00};
    end
`endif
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d          = state_q;
    trap_o           = 1'b0;
    mret_o           = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    busy_o           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (exc_valid_i || irq_take) begin
            state_d = ST_TRAP;
          end else if (mret_i) begin
            state_d = ST_MRET;
          end
        end
      end
      ST_TRAP: begin
        trap_o  = 1'b1;
        flush_o = 1'b1;
        busy_o  = 1'b1;
        state_d = ST_REDIRECT;
      end
      ST_MRET: begin
        mret_o  = 1'b1;
        flush_o = 1'b1;
        busy_o  = 1'b1;
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid_o = 1'b1;
        flush_o          = 1'b1;
        busy_o           = 1'b1;
        if (redirect_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Trap record: captured at acceptance, held until the next trap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q  <= 1'b0;
      code_q <= 4'd0;
      mepc_q <= 32'd0;
      tval_q <= 32'd0;
    end else if (accept) begin
      if (exc_valid_i) begin
        irq_q  <= 1'b0;
        code_q <= exc_cause_i;
        mepc_q <= pcM_i;
        tval_q <= exc_tval_i;
      end else if (irq_take) begin
        irq_q  <= 1'b1;
        code_q <= irq_code;
        mepc_q <= pcM_i;
        tval_q <= 32'd0;
      end
    end
  end

  // Redirect target: latched in the commit cycle, held through REDIRECT
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      target_q <= 32'd0;
    end else if (state_q == ST_TRAP) begin
      target_q <= trap_target;
    end else if (state_q == ST_MRET) begin
      target_q <= {csr_mepc_i[31:2], 2'b00};
    end
  end

  assign trap_irq_o    = irq_q;
  assign trap_code_o   = code_q;
  assign trap_mepc_o   = mepc_q;
  assign trap_mtval_o  = tval_q;
  assign redirect_pc_o = target_q;

endmodule
